// File: rtl/reward_sequencer.sv
// Shares one registered reward decoder among N_AGENT agents: grant, drive levels, wait one cycle, return the reward.
// Define RSEQ_FIXED_PRIO_EN for lowest-index-wins arbitration; round-robin is the default.
module reward_sequencer #(
  parameter int N_AGENT = 4,
  parameter int AGENT_W = 2,
  parameter int L_WIDTH = 4,
  parameter int R_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_AGENT-1:0]            req,
  input  logic [N_AGENT*4*L_WIDTH-1:0]  l_in,
  output logic [N_AGENT-1:0]            ack,
  output logic [L_WIDTH-1:0]            rd_l0,
  output logic [L_WIDTH-1:0]            rd_l1,
  output logic [L_WIDTH-1:0]            rd_l2,
  output logic [L_WIDTH-1:0]            rd_l3,
  input  logic signed [R_WIDTH-1:0]     rd_r,
  output logic                          r_valid,
  input  logic                          r_ready,
  output logic [AGENT_W-1:0]            r_agent,
  output logic signed [R_WIDTH-1:0]     r_data,
  output logic                          busy
);

  // Result handshake: r_data/r_agent are stable while r_valid is high; the
  // transfer happens on a rising edge where r_valid && r_ready.
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_e;

  state_e                      state_q, state_d;
  logic [N_AGENT-1:0]          ack_q, ack_d;
  logic [L_WIDTH-1:0]          rd_l0_q, rd_l0_d, rd_l1_q, rd_l1_d;
  logic [L_WIDTH-1:0]          rd_l2_q, rd_l2_d, rd_l3_q, rd_l3_d;
  logic                        r_valid_q, r_valid_d;
  logic [AGENT_W-1:0]          r_agent_q, r_agent_d;
  logic signed [R_WIDTH-1:0]   r_data_q, r_data_d;

  logic [AGENT_W-1:0]          winner;
  logic                        found;

`ifdef RSEQ_FIXED_PRIO_EN
  // Descending scan so the lowest requesting index is the last one written.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int i = N_AGENT - 1; i >= 0; i--) begin
      if (req[AGENT_W'(i)]) begin
        winner = AGENT_W'(i);
        found  = 1'b1;
      end
    end
  end
`else
  logic [AGENT_W-1:0] last_grant_q, last_grant_d;
  int                 idx;
  logic [AGENT_W-1:0] idx_w;

  // Search begins one past the previous winner and wraps modulo N_AGENT.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    idx_w  = '0;
    for (int i = 1; i <= N_AGENT; i++) begin
      idx   = (int'(last_grant_q) + i) % N_AGENT;
      idx_w = AGENT_W'(idx);
      if (!found && req[idx_w]) begin
        winner = idx_w;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    last_grant_d = last_grant_q;
    if (state_q == IDLE && found) last_grant_d = winner;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_grant_q <= AGENT_W'(N_AGENT - 1);
    else     last_grant_q <= last_grant_d;
  end
`endif

  always_comb begin
    state_d   = state_q;
    ack_d     = '0;
    rd_l0_d   = rd_l0_q;
    rd_l1_d   = rd_l1_q;
    rd_l2_d   = rd_l2_q;
    rd_l3_d   = rd_l3_q;
    r_valid_d = r_valid_q;
    r_agent_d = r_agent_q;
    r_data_d  = r_data_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          ack_d[winner] = 1'b1;
          r_agent_d     = winner;
          rd_l0_d       = l_in[(4*int'(winner)+0)*L_WIDTH +: L_WIDTH];
          rd_l1_d       = l_in[(4*int'(winner)+1)*L_WIDTH +: L_WIDTH];
          rd_l2_d       = l_in[(4*int'(winner)+2)*L_WIDTH +: L_WIDTH];
          rd_l3_d       = l_in[(4*int'(winner)+3)*L_WIDTH +: L_WIDTH];
          state_d       = ISSUE;
        end
      end
      // The decoder registers rd_l* at the end of ISSUE, so rd_r is valid in WAIT.
      ISSUE: state_d = WAIT;
      WAIT: begin
        r_data_d  = rd_r;
        r_valid_d = 1'b1;
        state_d   = HOLD;
      end
      HOLD: begin
        if (r_ready) begin
          r_valid_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      ack_q     <= '0;
      rd_l0_q   <= '0;
      rd_l1_q   <= '0;
      rd_l2_q   <= '0;
      rd_l3_q   <= '0;
      r_valid_q <= 1'b0;
      r_agent_q <= '0;
      r_data_q  <= '0;
    end else begin
      state_q   <= state_d;
      ack_q     <= ack_d;
      rd_l0_q   <= rd_l0_d;
      rd_l1_q   <= rd_l1_d;
      rd_l2_q   <= rd_l2_d;
      rd_l3_q   <= rd_l3_d;
      r_valid_q <= r_valid_d;
      r_agent_q <= r_agent_d;
      r_data_q  <= r_data_d;
    end
  end

  assign ack     = ack_q;
  assign rd_l0   = rd_l0_q;
  assign rd_l1   = rd_l1_q;
  assign rd_l2   = rd_l2_q;
  assign rd_l3   = rd_l3_q;
  assign r_valid = r_valid_q;
  assign r_agent = r_agent_q;
  assign r_data  = r_data_q;
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_reward_sequencer.sv
// Bench for reward_sequencer: directed scenarios plus random agents, checked cycle by cycle
// against a transaction-level model; a behavioural registered decoder drives rd_r.
module tb_reward_sequencer;
  localparam int N  = 4;
  localparam int AW = 2;
  localparam int LW = 4;
  localparam int RW = 16;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [N-1:0]          req = '0;
  logic [N*4*LW-1:0]     l_in = '0;
  logic [N-1:0]          ack;
  logic [LW-1:0]         rd_l0, rd_l1, rd_l2, rd_l3;
  logic signed [RW-1:0]  rd_r = '0;
  logic                  r_valid;
  logic                  r_ready = 1'b1;
  logic [AW-1:0]         r_agent;
  logic signed [RW-1:0]  r_data;
  logic                  busy;

  always #5 clk = ~clk;

  reward_sequencer #(.N_AGENT(N), .AGENT_W(AW), .L_WIDTH(LW), .R_WIDTH(RW)) dut (
    .clk(clk), .rst(rst), .req(req), .l_in(l_in), .ack(ack),
    .rd_l0(rd_l0), .rd_l1(rd_l1), .rd_l2(rd_l2), .rd_l3(rd_l3),
    .rd_r(rd_r), .r_valid(r_valid), .r_ready(r_ready),
    .r_agent(r_agent), .r_data(r_data), .busy(busy)
  );

  // Decoder stand-in: reward = (L1 + L3 - L2 - L0) * 6400, wrapped to RW bits.
  function automatic logic signed [RW-1:0] reward_of(input int l0, input int l1, input int l2, input int l3);
    int v;
    v = (l1 + l3 - l2 - l0) * 6400;
    return RW'(v);
  endfunction

  always @(posedge clk) rd_r <= reward_of(int'(rd_l0), int'(rd_l1), int'(rd_l2), int'(rd_l3));

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: m_age counts cycles since the grant (0 = no transaction in flight).
  int                    m_age, m_last, m_agent;
  logic [LW-1:0]         m_lv [4];
  logic signed [RW-1:0]  m_data;

  task automatic model_reset();
    m_age = 0; m_last = N - 1; m_agent = 0; m_data = '0;
    for (int k = 0; k < 4; k++) m_lv[k] = '0;
  endtask

  function automatic int pick();
`ifdef RSEQ_FIXED_PRIO_EN
    for (int i = 0; i < N; i++) if (req[i]) return i;
`else
    for (int i = 1; i <= N; i++) if (req[(m_last + i) % N]) return (m_last + i) % N;
`endif
    return -1;
  endfunction

  // Advance the model using the inputs that the next rising edge will sample.
  task automatic model_step();
    int w;
    case (m_age)
      0: if (req != '0) begin
        w = pick();
        m_agent = w; m_last = w; m_age = 1;
        for (int k = 0; k < 4; k++) m_lv[k] = l_in[(4*w+k)*LW +: LW];
      end
      1: m_age = 2;
      2: begin
        m_data = reward_of(int'(m_lv[0]), int'(m_lv[1]), int'(m_lv[2]), int'(m_lv[3]));
        m_age  = 3;
      end
      default: if (r_ready) m_age = 0;
    endcase
  endtask

  task automatic check_outputs(input string tag);
    logic [N-1:0] exp_ack;
    exp_ack = (m_age == 1) ? (N'(1) << m_agent) : '0;
    check({tag, "_ack"},     64'(ack), 64'(exp_ack));
    check({tag, "_valid"},   64'(r_valid), 64'(m_age == 3));
    check({tag, "_busy"},    64'(busy), 64'(m_age != 0));
    check({tag, "_agent"},   64'(r_agent), 64'(m_agent));
    check({tag, "_data"},    64'(r_data), 64'(m_data));
    check({tag, "_levels"},  64'({rd_l3, rd_l2, rd_l1, rd_l0}), 64'({m_lv[3], m_lv[2], m_lv[1], m_lv[0]}));
  endtask

  task automatic tick(input string tag);
    model_step();
    @(negedge clk);
    check_outputs(tag);
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; r_ready = 1'b1;
    repeat (2) @(negedge clk);
    model_reset();
    check_outputs("reset");
    rst = 1'b0;
  endtask

  task automatic set_levels(input int a, input int l0, input int l1, input int l2, input int l3);
    l_in = '0;
    l_in[(4*a+0)*LW +: LW] = LW'(l0);
    l_in[(4*a+1)*LW +: LW] = LW'(l1);
    l_in[(4*a+2)*LW +: LW] = LW'(l2);
    l_in[(4*a+3)*LW +: LW] = LW'(l3);
  endtask

  task automatic drive_random();
    for (int a = 0; a < N; a++) begin
      if (ack[a]) req[a] = 1'b0;
      else if (!req[a]) begin
        if ($urandom_range(0, 2) == 0) req[a] = 1'b1;
      end else if ($urandom_range(0, 19) == 0) req[a] = 1'b0;
    end
    l_in    = {$urandom, $urandom};
    r_ready = ($urandom_range(0, 3) != 0);
  endtask

  logic [AW-1:0] exp_q [$];

  initial begin
    logic signed [RW-1:0] held_data;
    logic [AW-1:0]        held_agent;
    int                   n_grant, last_c;

    model_reset();
    do_reset();

    // Agent 2 alone: ack one cycle after grant edge, reward three cycles after.
    set_levels(2, 0, 4, 4, 4);
    req = 4'b0100;
    tick("a2_issue");
    check("a2_ack", 64'(ack), 64'(4'b0100));
    req = '0;
    l_in = {$urandom, $urandom};
    tick("a2_wait");
    tick("a2_hold");
    check("a2_valid", 64'(r_valid), 64'd1);
    check("a2_agent", 64'(r_agent), 64'd2);
    check("a2_data",  64'(r_data),  64'(16'sd25600));
    tick("a2_idle");

    // Agent 0: levels that cancel to zero.
    set_levels(0, 0, 4, 8, 4);
    req = 4'b0001;
    tick("a0_issue");
    req = '0;
    tick("a0_wait");
    tick("a0_hold");
    check("a0_data", 64'(r_data), 64'd0);
    check("a0_agent", 64'(r_agent), 64'd0);
    tick("a0_idle");

    // All agents requesting with r_ready high: order and spacing of grants.
    do_reset();
    req = 4'b1111; r_ready = 1'b1; l_in = {$urandom, $urandom};
    for (int g = 0; g < 5; g++) begin
`ifdef RSEQ_FIXED_PRIO_EN
      exp_q.push_back(AW'(0));
`else
      exp_q.push_back(AW'(g % N));
`endif
    end
    n_grant = 0; last_c = -3;
    for (int c = 1; c <= 20; c++) begin
      tick("rr");
      if (ack != '0) begin
        check("rr_onehot", 64'($countones(ack)), 64'd1);
        check("rr_gap", 64'(c - last_c), 64'd4);
        last_c = c;
        n_grant++;
        for (int a = 0; a < N; a++)
          if (ack[a] && exp_q.size() > 0) check("rr_order", 64'(a), 64'(exp_q.pop_front()));
      end
      l_in = {$urandom, $urandom};
    end
    check("rr_count", 64'(n_grant), 64'd5);
    req = '0;
    repeat (4) tick("rr_drain");

    // Backpressure: hold for 5 cycles with req[1] pending.
    do_reset();
    l_in = {$urandom, $urandom};
    req = 4'b0001; r_ready = 1'b0;
    tick("bp_issue");
    req = 4'b0010;
    tick("bp_wait");
    tick("bp_hold");
    held_data = r_data; held_agent = r_agent;
    for (int c = 0; c < 5; c++) begin
      tick("bp_stall");
      check("bp_valid_held", 64'(r_valid), 64'd1);
      check("bp_data_held",  64'(r_data), 64'(held_data));
      check("bp_agent_held", 64'(r_agent), 64'(held_agent));
      check("bp_no_ack",     64'(ack), 64'd0);
    end
    r_ready = 1'b1;
    tick("bp_release");
    tick("bp_regrant");
    check("bp_ack1", 64'(ack), 64'(4'b0010));
    req = '0;
    repeat (3) tick("bp_drain");

    // Reset asserted during WAIT aborts the transaction.
    req = 4'b0001; l_in = {$urandom, $urandom};
    tick("rw_issue");
    req = '0;
    tick("rw_wait");
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_outputs("rw_async");
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick("rw_after");
      check("rw_no_valid", 64'(r_valid), 64'd0);
    end

    // Random agents, levels and consumer backpressure.
    for (int c = 0; c < 3000; c++) begin
      drive_random();
      tick("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reward_sequencer.md
# reward_sequencer

Time-multiplexes one registered reward decoder across `N_AGENT` intersection agents.
- Agents raise requests carrying their four queue-level codes.
- The sequencer grants one agent at a time, drives the decoder inputs, waits out the decoder's one-cycle register latency, and returns the signed reward tagged with the agent index.
- Sits between the per-intersection agent FSMs and the shared reward decoder inside the accelerator.

## Interface
Parameters:
- `N_AGENT`, 4: number of requesting agents, 2..16.
- `AGENT_W`, 2: index width, equals `clog2(N_AGENT)`.
- `L_WIDTH`, 4: level code width per road.
- `R_WIDTH`, 16: reward width (16 or 32), matches the decoder.

Ports:
- `clk`, in, 1: sole clock, rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `req`, in, `N_AGENT`: per-agent request; held high until the matching `ack`.
- `l_in`, in, `N_AGENT*4*L_WIDTH`: levels; agent a, road k at bits `[(4*a+k)*L_WIDTH +: L_WIDTH]`.
- `ack`, out, `N_AGENT`: one-cycle grant pulse, one-hot.
- `rd_l0`..`rd_l3`, out, `L_WIDTH` each: registered levels driven to the decoder.
- `rd_r`, in, signed `R_WIDTH`: decoder output, valid one cycle after `rd_l*` change.
- `r_valid`, out, 1: reward available.
- `r_ready`, in, 1: consumer accepts the reward.
- `r_agent`, out, `AGENT_W`: index of the agent owning `r_data`.
- `r_data`, out, signed `R_WIDTH`: captured reward.
- `busy`, out, 1: high in any state other than IDLE.

## Operation
FSM states are IDLE, ISSUE, WAIT, HOLD.
- IDLE:
  - If `req` is nonzero, select the winner.
  - Register the winner's four level fields into `rd_l0..3`.
  - Register `ack[winner]=1` and `r_agent=winner`, then go to ISSUE.
  - If `req` is zero, stay in IDLE.
- ISSUE:
  - `ack` is high for this one cycle only.
  - The decoder samples `rd_l*` at the end of this cycle.
  - Go to WAIT.
- WAIT:
  - `rd_r` is valid during this cycle.
  - Register `r_data=rd_r` and `r_valid=1`, then go to HOLD.
- HOLD:
  - `r_valid`, `r_data` and `r_agent` are held stable.
  - When `r_valid && r_ready`, clear `r_valid` and go to IDLE.
- Arbitration is round-robin:
  - The search starts at `last_grant+1` modulo `N_AGENT`.
  - `last_grant` updates on each grant.
  - `last_grant` resets to `N_AGENT-1`, so agent 0 wins first.
- Levels are sampled only at the grant edge. `l_in` changes afterwards do not affect the result.
- A request that drops before `ack` is not remembered.
- `rd_l*` keep their last value outside grants.
- No arithmetic is performed. `rd_r` passes through unmodified at `R_WIDTH`, including any overflow wrap produced in the decoder.

## Timing
- Grant edge at end of cycle T gives `ack` in T+1 and `r_valid` in T+3.
- With `r_ready` tied high, one reward completes every 4 cycles, giving the next grant at T+4.
- Backpressure: HOLD lasts until `r_ready`, and no new grant is made meanwhile.
- Simultaneous requests: exactly one `ack` bit. Losers keep `req` high and are served in later rounds.
- A request from the agent currently in HOLD, re-raised after its `ack`, is a new request. It is eligible at the next IDLE under normal round-robin.
- Reset values:
  - State IDLE.
  - `ack=0`, `r_valid=0`, `busy=0`.
  - `r_data=0`, `r_agent=0`, `rd_l0..3=0`.
  - `last_grant=N_AGENT-1`.
- Reset mid-operation aborts the transaction. No reward is emitted for the aborted grant.

## Configuration
- `RSEQ_FIXED_PRIO_EN`:
  - Defined: fixed priority, lowest index wins; `last_grant` is unused.
  - Undefined (default): round-robin as above.
- Nothing else changes with the macro.

## Test plan
- Reset then agent 2 requests with L0=0x0, L1..3=0x4:
  - `ack=4'b0100` one cycle after the grant edge.
  - `r_valid` at grant+3 with `r_agent=2`, `r_data=25600`.
- Agent 0 requests with L0=0x0, L1=0x4, L2=0x8, L3=0x4: `r_data=0`.
- All four `req` held high, `r_ready=1`:
  - Grants in order 0,1,2,3,0.
  - Spacing of 4 cycles; never two `ack` bits at once.
  - With the macro defined: agent 0 is always granted while its `req` stays high.
- `r_ready=0` for 5 cycles in HOLD with `req[1]` high:
  - `r_valid`, `r_data` and `r_agent` stay stable, and no `ack` occurs.
  - `ack[1]` follows one cycle after `r_ready` is raised.
- Change `l_in` for the granted agent during ISSUE: `r_data` reflects the levels sampled at the grant edge.
- Assert `rst` during WAIT: all outputs return to reset values immediately, and no `r_valid` pulse appears afterward.
